// File: rtl/dmem_block_backend_pkg.sv
// ---------------------------------------------------------------------------
// dmem_block_backend_pkg
//   Shared definitions for the block-granular main-memory backend and the
//   data cache that drives it: block/address widths and the backend FSM
//   state encoding.
// ---------------------------------------------------------------------------
package dmem_block_backend_pkg;

  // Widths shared with the dcache miss/writeback port.
  localparam int BLOCK_W    = 128;
  localparam int BLK_ADDR_W = 28;

  // Latency counter width; holds LATENCY-1 for LATENCY up to 15.
  localparam int CNT_W = 4;

  // Backend FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : dmem_block_backend_pkg

// File: rtl/dmem_block_backend.sv
// ---------------------------------------------------------------------------
// dmem_block_backend
//   Main-memory backend behind the data cache. Accepts one block read or
//   write, holds BUSYWAIT for a fixed LATENCY, performs the access on the
//   last BUSY edge, then spends one DONE cycle with BUSYWAIT low so the
//   cache has a defined completion cycle.
//
// Ports
//   CLK        system clock, rising edge
//   RESET      synchronous, active-high; clears FSM, READDATA and storage
//   READ       block read request
//   WRITE      block writeback request (wins over READ)
//   ADDRESS    block address; low IDX_W bits select the block (aliasing)
//   WRITEDATA  block to store, word0 = bits [31:0]
//   READDATA   registered read block, held until the next completed read
//   BUSYWAIT   high while a request is pending or in service
// ---------------------------------------------------------------------------
module dmem_block_backend
  import dmem_block_backend_pkg::*;
#(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 256,
  parameter int IDX_W   = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [BLK_ADDR_W-1:0] ADDRESS,
  input  logic [BLOCK_W-1:0]    WRITEDATA,
  output logic [BLOCK_W-1:0]    READDATA,
  output logic                  BUSYWAIT
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   counter;
  logic               wr_p0;
  logic               rd_p0;
  logic [IDX_W-1:0]   idx_p0;
  logic [BLOCK_W-1:0] wdata_p0;
  logic               accept;
  logic               access;
  logic               unused_addr_hi;

  logic [BLOCK_W-1:0] mem [DEPTH];

  // Upper address bits intentionally alias onto the same block index.
  assign unused_addr_hi = ^ADDRESS[BLK_ADDR_W-1:IDX_W];

  assign accept = (state == ST_IDLE) && (READ || WRITE);
  assign access = (state == ST_BUSY) && (counter == '0);

  // BUSYWAIT rises combinationally with the request so the cache stalls
  // in the very cycle it asks; DONE drops it for exactly one cycle.
  always_comb begin
    BUSYWAIT = 1'b0;
    if (!RESET) begin
      case (state)
        ST_IDLE: BUSYWAIT = READ || WRITE;
        ST_BUSY: BUSYWAIT = 1'b1;
        default: BUSYWAIT = 1'b0;
      endcase
    end
  end

  // ---- stage p0: request acceptance and latency count ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= ST_IDLE;
      counter <= '0;
      wr_p0   <= 1'b0;
      rd_p0   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (READ || WRITE) begin
            // Simultaneous strobes: the write is served, the read dropped.
            wr_p0   <= WRITE;
            rd_p0   <= READ && !WRITE;
            counter <= CNT_W'(LATENCY - 1);
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (counter != '0) begin
            counter <= counter - 1'b1;
          end else begin
            state <= ST_DONE;
          end
        end
        // Any strobe still high in DONE is the one just served; ignore it.
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request payload is captured once; later input changes are ignored.
  always_ff @(posedge CLK) begin
    if (accept) begin
      idx_p0   <= ADDRESS[IDX_W-1:0];
      wdata_p0 <= WRITEDATA;
    end
  end

  // ---- stage p1: storage access on the final BUSY edge ----
  // Reset wins over a pending access, so an aborted write is never committed.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      READDATA <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i[IDX_W-1:0]] <= '0;
      end
    end else if (access) begin
      if (wr_p0) begin
        mem[idx_p0] <= wdata_p0;
      end else if (rd_p0) begin
        READDATA <= mem[idx_p0];
      end
    end
  end

endmodule : dmem_block_backend

// File: tb/tb_dmem_block_backend.sv
// ---------------------------------------------------------------------------
// tb_dmem_block_backend
//   Directed bench for dmem_block_backend: a table of block requests with
//   expected BUSYWAIT length and READDATA in the DONE cycle, plus sequences
//   for reset behaviour, reset mid-write, a stale strobe held through DONE,
//   and a second instance built with LATENCY=1.
// ---------------------------------------------------------------------------
module tb_dmem_block_backend;

  logic         clk;
  logic         reset;
  logic         rd;
  logic         wr;
  logic [27:0]  addr;
  logic [127:0] wdata;
  logic [127:0] rdata;
  logic         busy;

  logic         rd1;
  logic         wr1;
  logic [27:0]  addr1;
  logic [127:0] wdata1;
  logic [127:0] rdata1;
  logic         busy1;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_block_backend #(.LATENCY(5), .DEPTH(256), .IDX_W(8)) dut (
    .CLK(clk), .RESET(reset), .READ(rd), .WRITE(wr), .ADDRESS(addr),
    .WRITEDATA(wdata), .READDATA(rdata), .BUSYWAIT(busy)
  );

  dmem_block_backend #(.LATENCY(1), .DEPTH(256), .IDX_W(8)) dut_l1 (
    .CLK(clk), .RESET(reset), .READ(rd1), .WRITE(wr1), .ADDRESS(addr1),
    .WRITEDATA(wdata1), .READDATA(rdata1), .BUSYWAIT(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    int           exp_busy;
    logic [127:0] exp_rdata;
    string        name;
  } vec_t;

  localparam logic [127:0] PAT = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request on the LATENCY=5 instance, count BUSYWAIT-high cycles
  // and capture READDATA in the DONE cycle; strobes drop after DONE.
  task automatic do_req(input logic r, input logic w, input logic [27:0] a,
                        input logic [127:0] d, output int cnt,
                        output logic [127:0] q);
    bit done;
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    cnt  = 0;
    done = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!busy) begin
        done = 1;
        break;
      end
      cnt++;
      @(negedge clk);
    end
    q = rdata;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: BUSYWAIT never fell for addr %h", a);
    end
    @(posedge clk);
    #1;
    rd = 0; wr = 0;
  endtask

  task automatic do_req1(input logic r, input logic w, input logic [27:0] a,
                         input logic [127:0] d, output int cnt,
                         output logic [127:0] q);
    bit done;
    @(negedge clk);
    rd1 = r; wr1 = w; addr1 = a; wdata1 = d;
    cnt  = 0;
    done = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!busy1) begin
        done = 1;
        break;
      end
      cnt++;
      @(negedge clk);
    end
    q = rdata1;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_l1: BUSYWAIT never fell for addr %h", a);
    end
    @(posedge clk);
    #1;
    rd1 = 0; wr1 = 0;
  endtask

  initial begin
    vec_t         vecs[10];
    int           cnt;
    logic [127:0] q;
    logic [13:0]  pat;
    logic [127:0] q_first;
    logic [127:0] q_second;

    reset = 1; rd = 0; wr = 0; addr = '0; wdata = '0;
    rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;

    // Reset for two cycles with a read strobe present: BUSYWAIT held low.
    @(negedge clk);
    rd = 1;
    #1 check("busy_forced_low_in_reset", 128'(busy), 128'd0);
    @(posedge clk);
    @(posedge clk);
    #1 check("busy_low_in_reset_2", 128'(busy), 128'd0);
    @(negedge clk);
    reset = 0; rd = 0;
    #1;
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_readdata", rdata, 128'd0);

    vecs[0] = '{1'b1, 1'b0, 28'h0000010, 128'h0,  6, 128'h0, "rd_after_reset"};
    vecs[1] = '{1'b0, 1'b1, 28'h0000023, PAT,     6, 128'h0, "wr_pat"};
    vecs[2] = '{1'b1, 1'b0, 28'h0000023, 128'h0,  6, PAT,    "rd_pat"};
    vecs[3] = '{1'b0, 1'b1, 28'h0000105, 128'h1,  6, PAT,    "wr_alias"};
    vecs[4] = '{1'b1, 1'b0, 28'h0000005, 128'h0,  6, 128'h1, "rd_alias"};
    vecs[5] = '{1'b1, 1'b0, 28'hABCD123, 128'h0,  6, PAT,    "rd_alias_hi"};
    vecs[6] = '{1'b0, 1'b1, 28'h0000007, 128'hAA, 6, PAT,    "wr_aa"};
    vecs[7] = '{1'b1, 1'b0, 28'h0000007, 128'h0,  6, 128'hAA, "rd_aa"};
    vecs[8] = '{1'b1, 1'b1, 28'h0000007, 128'hBB, 6, 128'hAA, "rdwr_both"};
    vecs[9] = '{1'b1, 1'b0, 28'h0000007, 128'h0,  6, 128'hBB, "rd_bb"};

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, cnt, q);
      check({vecs[i].name, "_busy"}, 128'(cnt), 128'(vecs[i].exp_busy));
      check({vecs[i].name, "_rdata"}, q, vecs[i].exp_rdata);
    end

    // Reset in the 3rd BUSY cycle of a write aborts it.
    @(negedge clk);
    wr = 1; addr = 28'h9; wdata = 128'hFF;
    @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk);
    #1 check("midwr_busy_before_reset", 128'(busy), 128'd1);
    reset = 1; wr = 0;
    #1 check("midwr_busy_forced_low", 128'(busy), 128'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check("midwr_busy_after_reset", 128'(busy), 128'd0);
    check("midwr_readdata_cleared", rdata, 128'd0);
    do_req(1'b1, 1'b0, 28'h9, 128'h0, cnt, q);
    check("midwr_rd9_busy", 128'(cnt), 128'd6);
    check("midwr_rd9_rdata", q, 128'd0);
    do_req(1'b1, 1'b0, 28'h7, 128'h0, cnt, q);
    check("reset_cleared_idx7", q, 128'd0);

    // Stale strobe: READ held through DONE yields exactly two accesses.
    do_req(1'b0, 1'b1, 28'h40, 128'h1234, cnt, q);
    @(negedge clk);
    rd = 1; addr = 28'h40;
    pat = '0;
    q_first = '0;
    q_second = '0;
    for (int c = 0; c < 14; c++) begin
      #1;
      pat[c] = busy;
      if (c == 6)  q_first  = rdata;
      if (c == 13) q_second = rdata;
      @(negedge clk);
    end
    rd = 0;
    check("stale_busy_pattern", 128'(pat), 128'h1FBF);
    check("stale_first_rdata", q_first, 128'h1234);
    check("stale_second_rdata", q_second, 128'h1234);
    @(negedge clk);
    #1 check("stale_idle_after", 128'(busy), 128'd0);

    // LATENCY=1 instance: BUSYWAIT high for 2 cycles.
    do_req1(1'b0, 1'b1, 28'h3, 128'h55, cnt, q);
    check("l1_wr_busy", 128'(cnt), 128'd2);
    check("l1_wr_rdata", q, 128'd0);
    do_req1(1'b1, 1'b0, 28'h3, 128'h0, cnt, q);
    check("l1_rd_busy", 128'(cnt), 128'd2);
    check("l1_rd_rdata", q, 128'h55);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_dmem_block_backend

// File: doc/dmem_block_backend.md
Name: dmem_block_backend

Overview:
- Block-granular main-memory backend sitting directly downstream of the data cache's miss/writeback port.
- Consumes the cache's block read/write requests: 28-bit block address, 128-bit block data, read/write strobes.
- Returns a 128-bit block after a fixed, parameterised latency; holds BUSYWAIT high until the data is valid.
- Replaces the bare memory behind the cache controller with an explicit IDLE/BUSY/DONE handshake so the cache FSM has a defined completion cycle.

Parameters:
- LATENCY, 5, access latency in clock cycles counted from the first BUSY edge (legal 1..15).
- DEPTH, 256, number of 128-bit blocks stored (power of two).
- IDX_W, 8, log2(DEPTH): low ADDRESS bits used as block index.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- READ  input  1  block read request from dcache.
- WRITE  input  1  block write (writeback) request from dcache.
- ADDRESS  input  28  block address (byte address [31:4]).
- WRITEDATA  input  128  block to store; word0 = bits [31:0].
- READDATA  output  128  block returned for a read; registered.
- BUSYWAIT  output  1  high while a request is pending or in service.

Behaviour:
- Clock and reset (decided): one clock CLK; RESET is synchronous and active-high.
- Reset (edge with RESET=1):
  - state <= IDLE, counter <= 0, READDATA <= 0, all DEPTH blocks <= 0.
  - BUSYWAIT forced 0 while RESET is high.
  - Reset mid-operation aborts the access: a pending write is not committed and READDATA is not updated.
- States:
  - IDLE: BUSYWAIT = READ|WRITE (combinational), so it rises in the same cycle as the request. On an edge with READ|WRITE: latch op, index = ADDRESS[IDX_W-1:0] (upper bits ignored, aliasing), WRITEDATA; counter <= LATENCY-1; go to BUSY.
  - BUSY: BUSYWAIT = 1. On each edge: if counter != 0, decrement. If counter == 0, perform the access (write: mem[index] <= latched data; read: READDATA <= mem[index]) and go to DONE.
  - DONE: BUSYWAIT = 0 for exactly one cycle. The cache samples READDATA and drops READ/WRITE at this edge. Always go to IDLE; any request seen in DONE is ignored, so a stale strobe cannot be served twice.
- Timing:
  - BUSYWAIT is high for exactly LATENCY+1 cycles per request: 1 IDLE cycle plus LATENCY BUSY cycles.
  - Back-to-back requests: the minimum issue interval is LATENCY+2 cycles.
- Simultaneous READ and WRITE: write wins; no read data is returned and READDATA holds its previous value.
- Inputs that change during BUSY are ignored; only the values latched at acceptance are used.
- READDATA holds its value until the next completed read or reset; writes never alter READDATA.
- Write then read of the same index returns the new data (the write is committed before DONE).

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - BLOCK_W=128 and BLK_ADDR_W=28, shared with the dcache.
- Single module; no sub-module needed (counter and FSM are about 30 lines).
- Storage is a behavioural reg array.

Test Plan:
- Reset read: assert RESET for 2 cycles, release, then READ=1 with ADDRESS=28'h0000010 -> BUSYWAIT high for 6 cycles, DONE cycle READDATA=128'h0, then back to IDLE.
- Write then read: WRITE with ADDRESS=28'h0000023, WRITEDATA=128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D until BUSYWAIT falls; then READ the same address -> READDATA equals that value in the DONE cycle; each request has BUSYWAIT high for 6 cycles.
- Aliasing: write 128'h1 to ADDRESS=28'h0000105, then read 28'h0000005 -> READDATA=128'h1 (index 8'h05).
- Simultaneous strobes: preload index 7 with 128'hAA, then READ=WRITE=1 at 28'h7 with WRITEDATA=128'hBB -> READDATA unchanged; a later read returns 128'hBB.
- Reset mid-write: WRITE 128'hFF to 28'h9 and assert RESET in the 3rd BUSY cycle -> BUSYWAIT 0 next cycle, state IDLE; a subsequent read of 28'h9 returns 128'h0.
- Stale strobe: hold READ=1 through DONE and one extra cycle -> exactly two accesses, with BUSYWAIT low for one cycle between them (issue interval 7 cycles with LATENCY=5); LATENCY=1 build -> BUSYWAIT high for 2 cycles.
